// File: rtl/act_stream_packer.sv
// Streams 4-bit samples from a read-only memory and packs each run of 2*M1
// samples into a pair of zero-extended activation vectors behind a valid/ready register.
module act_stream_packer #(
  parameter int K1 = 8,
  parameter int M1 = 11,
  parameter int SW = 4,
  parameter int AW = 13
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [15:0]      num_pairs,
  output logic             mem_rd_en,
  output logic [AW-1:0]    mem_addr,
  input  logic [SW-1:0]    mem_rdata,
  output logic [M1*K1-1:0] activation0a,
  output logic [M1*K1-1:0] activation1a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  localparam int NL = 2 * M1;
  localparam int CW = $clog2(NL + 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_FINISH} state_t;

  state_t state_q, state_d;

  logic [AW-1:0]          addr_q, addr_d;
  logic [CW-1:0]          rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]          ridx_q;
  logic                   rvld_q;
  logic [15:0]            left_q, left_d;
  logic [NL-1:0][K1-1:0]  lane_w;
  logic [NL-1:0][K1-1:0]  out_q;
  logic                   out_vld_q, busy_q, done_q;

  logic rd_en, mv, more, last_arr, out_free, st_go;

  assign st_go    = (state_q == S_IDLE) && start;
  assign out_free = !out_vld_q || out_ready;
  assign last_arr = (state_q == S_FETCH) && rvld_q && (ridx_q == CW'(NL - 1));
  assign mv       = (last_arr || (state_q == S_HOLD)) && out_free;
  assign more     = (left_q != 16'd1);

  // Assembly buffer: sample j lands in combined lane NL-1-j, so the upper M1
  // lanes form activation0a and the lower M1 lanes activation1a. The lane view
  // bypasses the arriving sample so the final one can move out without a bubble.
  for (genvar l = 0; l < NL; l++) begin : g_lane
    logic          wr;
    logic [SW-1:0] smp_q;
    assign wr = rvld_q && (ridx_q == CW'(NL - 1 - l));
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)   smp_q <= '0;
      else if (wr) smp_q <= mem_rdata;
    end
    assign lane_w[l] = K1'(wr ? mem_rdata : smp_q);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = (num_pairs == 16'd0) ? S_FINISH : S_FETCH;
      S_FETCH: begin
        if (last_arr && !out_free)
          state_d = S_HOLD;
        else if ((left_q == 16'd0) && out_vld_q && out_ready)
          state_d = S_FINISH;
      end
      S_HOLD:   if (out_free) state_d = S_FETCH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs: the move cycle also issues the first read of the next pair
  always_comb begin
    rd_en = ((state_q == S_FETCH) && (rd_cnt_q < CW'(NL))) || (mv && more);
  end

  always_comb begin
    addr_d   = addr_q;
    rd_cnt_d = rd_cnt_q;
    left_d   = left_q;
    if (st_go) begin
      addr_d   = base_addr;
      rd_cnt_d = '0;
      left_d   = num_pairs;
    end else begin
      if (rd_en) addr_d = addr_q + AW'(1);
      if (mv) begin
        left_d = left_q - 16'd1;
        if (more) rd_cnt_d = CW'(1);
      end else if (rd_en) begin
        rd_cnt_d = rd_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q    <= '0;
      rd_cnt_q  <= '0;
      left_q    <= '0;
      ridx_q    <= '0;
      rvld_q    <= 1'b0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      rd_cnt_q <= rd_cnt_d;
      left_q   <= left_d;
      ridx_q   <= mv ? '0 : rd_cnt_q;
      rvld_q   <= rd_en;
      if (mv) out_q <= lane_w;
      if (mv)             out_vld_q <= 1'b1;
      else if (out_ready) out_vld_q <= 1'b0;
      if (st_go)                      busy_q <= 1'b1;
      else if (state_q == S_FINISH)   busy_q <= 1'b0;
      done_q <= (state_q == S_FINISH);
    end
  end

  assign mem_rd_en    = rd_en;
  assign mem_addr     = addr_q;
  assign activation0a = out_q[NL-1:M1];
  assign activation1a = out_q[M1-1:0];
  assign out_valid    = out_vld_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_act_stream_packer.sv
// Directed bench for act_stream_packer: memory model returns addr mod 16 one
// cycle after each read; a negedge monitor scores every accepted pair.
module tb_act_stream_packer;
  localparam int K1 = 8, M1 = 11, SW = 4, AW = 13, NL = 22;
  localparam logic [M1*K1-1:0] A0_B0 = 88'h000102030405060708090A;
  localparam logic [M1*K1-1:0] A1_B0 = 88'h0B0C0D0E0F000102030405;
  localparam logic [M1*K1-1:0] A0_WR = 88'h0E0F000102030405060708;
  localparam logic [M1*K1-1:0] A1_WR = 88'h090A0B0C0D0E0F00010203;

  logic clk = 0, rstn = 0, start = 0, out_ready = 1;
  logic [AW-1:0] base_addr = '0;
  logic [15:0] num_pairs = '0;
  logic mem_rd_en, out_valid, busy, done;
  logic [AW-1:0] mem_addr;
  logic [SW-1:0] mem_rdata = '0;
  logic [M1*K1-1:0] activation0a, activation1a;

  act_stream_packer #(.K1(K1), .M1(M1), .SW(SW), .AW(AW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .num_pairs(num_pairs),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .activation0a(activation0a), .activation1a(activation1a),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) mem_rdata <= mem_rd_en ? mem_addr[3:0] : 4'hA;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [M1*K1-1:0] exp_vec(input int base, input int p, input int half);
    logic [M1*K1-1:0] v;
    int a;
    v = '0;
    for (int j = 0; j < M1; j++) begin
      a = (base + NL * p + half * M1 + j) % (1 << AW);
      v[(M1-1-j)*K1 +: K1] = K1'(a % 16);
    end
    return v;
  endfunction

  // monitor state (written only by the monitor)
  int nreads = 0, total_acc = 0, nvld = 0, first_addr = 0, last_addr = 0;
  int last_rise = 0, done_cyc = 0, last_acc_cyc = 0;
  int acc_cyc [4];
  logic [M1*K1-1:0] cap0 = '0, cap1 = '0;
  logic vld_prev = 0;
  // monitor controls (written only by the stimulus)
  int mon_base = 0, acc0 = 0, rd0 = 0, gap_from = 0;
  bit gap_en = 0;

  always @(negedge clk) begin : mon
    int p;
    p = total_acc - acc0;
    if (mem_rd_en) begin
      if (nreads == rd0) first_addr <= int'(mem_addr);
      last_addr <= int'(mem_addr);
      nreads <= nreads + 1;
    end
    if (out_valid) nvld <= nvld + 1;
    if (out_valid && out_ready) begin
      chk("pair_a0", activation0a, exp_vec(mon_base, p, 0));
      chk("pair_a1", activation1a, exp_vec(mon_base, p, 1));
      if (p == 0) begin cap0 <= activation0a; cap1 <= activation1a; end
      if (p < 4) acc_cyc[p] <= cyc;
      last_acc_cyc <= cyc;
      total_acc <= total_acc + 1;
    end
    if (out_valid && !vld_prev) begin
      if (gap_en && last_rise >= gap_from) chk("vld_gap", cyc - last_rise, NL);
      last_rise <= cyc;
    end
    vld_prev <= out_valid;
    if (done) done_cyc <= cyc;
  end

  task automatic drv; @(posedge clk); #1; endtask
  task automatic smp; @(negedge clk); #1; endtask

  task automatic arm(input int b);
    mon_base = b; acc0 = total_acc; rd0 = nreads;
  endtask

  task automatic go(input int b, input int n);
    drv; base_addr = AW'(b); num_pairs = 16'(n); start = 1;
    drv; start = 0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      smp;
      if (done) seen = 1;
    end
    chk("done_seen", seen, 1);
    if (seen) begin
      smp;
      chk("done_pulse", done, 0);
      chk("busy_after", busy, 0);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd"}, mem_rd_en, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_a0"}, activation0a, 0);
    chk({tag, "_a1"}, activation1a, 0);
    chk({tag, "_vld"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    int nv0;
    bit seen;
    // reset state
    repeat (3) smp;
    chk_zero("rst");
    drv; rstn = 1;
    drv;

    // single pair, base 0
    arm(0); nv0 = nvld;
    go(0, 1);
    wait_done(100);
    chk("t1_a0", cap0, A0_B0);
    chk("t1_a1", cap1, A1_B0);
    chk("t1_nvld", nvld - nv0, 1);
    chk("t1_reads", nreads - rd0, NL);
    chk("t1_done_lat", done_cyc - last_acc_cyc, 2);

    // zero pairs, start held while busy
    arm(0);
    drv; base_addr = '0; num_pairs = 16'd0; start = 1;
    drv; num_pairs = 16'd5;
    smp;
    chk("t2_done_early", done, 0);
    chk("t2_busy", busy, 1);
    chk("t2_rd", mem_rd_en, 0);
    drv; start = 0;
    smp;
    chk("t2_done", done, 1);
    chk("t2_busy_clr", busy, 0);
    repeat (5) smp;
    chk("t2_reads", nreads - rd0, 0);
    chk("t2_idle_busy", busy, 0);
    chk("t2_idle_vld", out_valid, 0);

    // 240 pairs at full rate, spurious start mid-stream
    arm(0); gap_from = cyc; gap_en = 1;
    go(0, 240);
    repeat (300) smp;
    drv; base_addr = 13'd100; num_pairs = 16'd3; start = 1;
    drv; start = 0;
    wait_done(6000);
    gap_en = 0;
    chk("t3_reads", nreads - rd0, 5280);
    chk("t3_last_addr", last_addr, 5279);
    chk("t3_first_addr", first_addr, 0);
    chk("t3_pairs", total_acc - acc0, 240);

    // backpressure during pair 0
    drv; out_ready = 0;
    arm(0);
    go(0, 3);
    for (int i = 0; i < 50; i++) begin
      smp;
      if (i == 29 || i == 49) begin
        chk("t4_vld", out_valid, 1);
        chk("t4_a0", activation0a, A0_B0);
        chk("t4_a1", activation1a, A1_B0);
      end
    end
    chk("t4_rd_off", mem_rd_en, 0);
    chk("t4_busy", busy, 1);
    chk("t4_reads_hold", nreads - rd0, 2 * NL);
    drv; out_ready = 1;
    wait_done(200);
    chk("t4_pairs", total_acc - acc0, 3);
    chk("t4_b2b", acc_cyc[1] - acc_cyc[0], 1);
    chk("t4_reads", nreads - rd0, 3 * NL);

    // address wrap
    arm(8190);
    go(8190, 1);
    wait_done(100);
    chk("t5_a0", cap0, A0_WR);
    chk("t5_a1", cap1, A1_WR);
    chk("t5_first", first_addr, 8190);
    chk("t5_last", last_addr, 19);
    chk("t5_reads", nreads - rd0, NL);

    // reset mid-stream at read 10 of pair 3, then restart
    arm(0);
    go(0, 5);
    seen = 0;
    for (int k = 0; k < 300 && !seen; k++) begin
      smp;
      if (mem_rd_en && mem_addr == 13'd76) seen = 1;
    end
    chk("t6_reached", seen, 1);
    chk("t6_pairs_pre", total_acc - acc0, 3);
    rstn = 0;
    #1;
    chk_zero("t6_rst");
    repeat (2) drv;
    rstn = 1;
    drv;
    arm(0);
    go(0, 1);
    wait_done(100);
    chk("t6_a0", cap0, A0_B0);
    chk("t6_a1", cap1, A1_B0);
    chk("t6_reads", nreads - rd0, NL);
    chk("t6_pairs", total_acc - acc0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
